// File: rtl/hidden_cpu_pkg.sv
// Shared opcodes, MISC sub-codes, FSM states and register reset values for the HiddenCPU core.
// Used by hidden_cpu_alu and hidden_cpu_core (optional macro HIDDENCPU_RAM_CLEAR_EN lives in the core).
package hidden_cpu_pkg;

    typedef enum logic [1:0] {
        OP_ADD  = 2'b00,
        OP_SUB  = 2'b01,
        OP_MISC = 2'b10,
        OP_NAND = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        SUB_LOAD   = 2'b00,
        SUB_STORE  = 2'b01,
        SUB_BCF    = 2'b10,
        SUB_TOGGLE = 2'b11
    } sub_e;

    typedef enum logic [1:0] {
        ST_INIT = 2'b00,
        ST_EXEC = 2'b01,
        ST_RD   = 2'b10
    } state_e;

    localparam int NUM_REGS = 4;

    // Each register resets to its own index: r0..r3 = 0..3.
    function automatic logic [1:0] reg_rst_val(input logic [1:0] idx);
        return idx;
    endfunction

endpackage

// File: rtl/hidden_cpu_alu.sv
// Combinational ADD/SUB/NAND datapath; carry_out is carry for ADD, borrow for SUB, 0 otherwise.
module hidden_cpu_alu
    import hidden_cpu_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic [1:0]        op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] result,
    output logic              carry_out
);

    logic [DATA_W:0] ext_s;

    // Widened arithmetic: the extra top bit is carry (ADD) or borrow (SUB).
    always_comb begin
        ext_s     = '0;
        result    = '0;
        carry_out = 1'b0;
        case (op_e'(op))
            OP_ADD: begin
                ext_s     = {1'b0, a} + {1'b0, b};
                result    = ext_s[DATA_W-1:0];
                carry_out = ext_s[DATA_W];
            end
            OP_SUB: begin
                ext_s     = {1'b0, a} - {1'b0, b};
                result    = ext_s[DATA_W-1:0];
                carry_out = ext_s[DATA_W];
            end
            OP_NAND: begin
                result    = ~(a & b);
                carry_out = 1'b0;
            end
            default: begin
                result    = '0;
                carry_out = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/hidden_cpu_core.sv
// HiddenCPU execution core: register file, PC, carry, data RAM and EXEC/RD/INIT control.
// Define HIDDENCPU_RAM_CLEAR_EN to zero the RAM with a post-reset sweep before accepting instructions.
module hidden_cpu_core
    import hidden_cpu_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int RAM_DEPTH = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              instr_valid,
    input  logic [5:0]        instr,
    output logic              instr_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              carry,
    output logic              sel_out
);

    localparam int RAM_AW = $clog2(RAM_DEPTH);

`ifdef HIDDENCPU_RAM_CLEAR_EN
    localparam state_e RESET_STATE = ST_INIT;
    logic [RAM_AW-1:0] sweep_r;
`else
    localparam state_e RESET_STATE = ST_EXEC;
`endif

    state_e            state_r;
    logic [DATA_W-1:0] regs_r [NUM_REGS];
    logic [DATA_W-1:0] pc_r;
    logic [DATA_W-1:0] rdata_r;
    logic              carry_r;
    logic              sel_out_r;
    logic [DATA_W-1:0] ram_r [RAM_DEPTH];

    op_e               op_s;
    sub_e              sub_s;
    logic [1:0]        ra_s;
    logic [1:0]        rb_s;
    logic              accept_s;
    logic              store_s;
    logic              bcf_taken_s;
    logic [RAM_AW-1:0] addr_s;
    logic [DATA_W-1:0] pc_next_s;
    logic [DATA_W-1:0] alu_res_s;
    logic              alu_carry_s;

    assign op_s        = op_e'(instr[5:4]);
    assign ra_s        = instr[3:2];
    assign rb_s        = instr[1:0];
    assign sub_s       = sub_e'(instr[1:0]);
    assign instr_ready = (state_r == ST_EXEC);
    assign accept_s    = instr_valid & instr_ready;
    assign addr_s      = RAM_AW'({regs_r[1], regs_r[2]});
    assign store_s     = accept_s & (op_s == OP_MISC) & (sub_s == SUB_STORE);
    assign bcf_taken_s = (op_s == OP_MISC) & (sub_s == SUB_BCF) & carry_r;
    assign pc_next_s   = bcf_taken_s ? (pc_r + regs_r[3]) : (pc_r + DATA_W'(1));

    assign out_data = sel_out_r ? pc_r : regs_r[3];
    assign carry    = carry_r;
    assign sel_out  = sel_out_r;

    hidden_cpu_alu #(.DATA_W(DATA_W)) u_alu (
        .op        (instr[5:4]),
        .a         (regs_r[ra_s]),
        .b         (regs_r[rb_s]),
        .result    (alu_res_s),
        .carry_out (alu_carry_s)
    );

    // Control FSM plus all architectural state except the RAM array.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= RESET_STATE;
            pc_r      <= '0;
            carry_r   <= 1'b0;
            sel_out_r <= 1'b0;
            rdata_r   <= '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_r[i] <= DATA_W'(reg_rst_val(2'(i)));
            end
`ifdef HIDDENCPU_RAM_CLEAR_EN
            sweep_r   <= '0;
`endif
        end else begin
            case (state_r)
                ST_INIT: begin
`ifdef HIDDENCPU_RAM_CLEAR_EN
                    sweep_r <= sweep_r + RAM_AW'(1);
                    if (sweep_r == RAM_AW'(RAM_DEPTH - 1)) begin
                        state_r <= ST_EXEC;
                    end
`else
                    state_r <= ST_EXEC;
`endif
                end
                ST_EXEC: begin
                    if (accept_s) begin
                        pc_r <= pc_next_s;
                        case (op_s)
                            OP_ADD, OP_SUB: begin
                                regs_r[ra_s] <= alu_res_s;
                                carry_r      <= alu_carry_s;
                            end
                            OP_NAND: regs_r[ra_s] <= alu_res_s;
                            OP_MISC: begin
                                case (sub_s)
                                    SUB_LOAD: begin
                                        rdata_r <= ram_r[addr_s];
                                        state_r <= ST_RD;
                                    end
                                    SUB_TOGGLE: sel_out_r <= ~sel_out_r;
                                    default: ;
                                endcase
                            end
                            default: ;
                        endcase
                    end
                end
                ST_RD: begin
                    regs_r[3] <= rdata_r;
                    state_r   <= ST_EXEC;
                end
                default: state_r <= RESET_STATE;
            endcase
        end
    end

    // Data RAM writes; reset blocks every write so a dropped STORE leaves no trace.
    always_ff @(posedge clk) begin
`ifdef HIDDENCPU_RAM_CLEAR_EN
        if (!rst) begin
            if (state_r == ST_INIT) begin
                ram_r[sweep_r] <= '0;
            end else if (store_s) begin
                ram_r[addr_s] <= regs_r[3];
            end
        end
`else
        if (!rst && store_s) begin
            ram_r[addr_s] <= regs_r[3];
        end
`endif
    end

endmodule

// File: tb/tb_hidden_cpu_core.sv
// Self-checking bench for hidden_cpu_core: directed test-plan sequence, then random instructions
// and occasional resets compared every cycle against an instruction-level reference model.
module tb_hidden_cpu_core;

    localparam int DATA_W    = 8;
    localparam int RAM_DEPTH = 16;
    localparam int MASK      = (1 << DATA_W) - 1;

    logic              clk = 1'b0;
    logic              rst;
    logic              instr_valid;
    logic [5:0]        instr;
    logic              instr_ready;
    logic [DATA_W-1:0] out_data;
    logic              carry;
    logic              sel_out;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model state: plain integers, one update per clock edge.
    int m_r [4];
    int m_pc, m_carry, m_sel, m_pend, m_ldval, m_sweep;
    int m_ram [RAM_DEPTH];
    bit m_known [RAM_DEPTH];

    hidden_cpu_core #(.DATA_W(DATA_W), .RAM_DEPTH(RAM_DEPTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_ready (instr_ready),
        .out_data    (out_data),
        .carry       (carry),
        .sel_out     (sel_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        vectors++;
        if (got != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic bit m_ready();
        return (m_sweep == 0) && (m_pend == 0);
    endfunction

    function automatic int m_addr();
        return ((m_r[1] << DATA_W) | m_r[2]) % RAM_DEPTH;
    endfunction

    task automatic model_edge(input bit r, input bit v, input logic [5:0] ins);
        int op, a, b, s, npc;
        if (r) begin
            m_r = '{0, 1, 2, 3};
            m_pc = 0; m_carry = 0; m_sel = 0; m_pend = 0;
`ifdef HIDDENCPU_RAM_CLEAR_EN
            m_sweep = RAM_DEPTH;
`else
            m_sweep = 0;
`endif
            for (int i = 0; i < RAM_DEPTH; i++) m_known[i] = 1'b0;
        end else if (m_sweep > 0) begin
            m_ram[RAM_DEPTH - m_sweep]   = 0;
            m_known[RAM_DEPTH - m_sweep] = 1'b1;
            m_sweep--;
        end else if (m_pend != 0) begin
            m_r[3] = m_ldval;
            m_pend = 0;
        end else if (v) begin
            op = int'(ins[5:4]); a = int'(ins[3:2]); b = int'(ins[1:0]);
            npc = m_pc + 1;
            case (op)
                0: begin
                    s = m_r[a] + m_r[b];
                    m_carry = (s > MASK) ? 1 : 0;
                    m_r[a] = s & MASK;
                end
                1: begin
                    m_carry = (m_r[a] < m_r[b]) ? 1 : 0;
                    m_r[a] = (m_r[a] - m_r[b]) & MASK;
                end
                3: m_r[a] = ~(m_r[a] & m_r[b]) & MASK;
                default: begin
                    case (b)
                        0: begin m_ldval = m_ram[m_addr()]; m_pend = 1; end
                        1: begin m_ram[m_addr()] = m_r[3]; m_known[m_addr()] = 1'b1; end
                        2: if (m_carry != 0) npc = m_pc + m_r[3];
                        default: m_sel = 1 - m_sel;
                    endcase
                end
            endcase
            m_pc = npc & MASK;
        end
    endtask

    // One clock: drive, let the edge happen, advance the model, compare at the falling edge.
    task automatic step(input bit r, input bit v, input logic [5:0] ins);
        rst = r; instr_valid = v; instr = ins;
        @(posedge clk);
        model_edge(r, v, ins);
        @(negedge clk);
        check("instr_ready", int'(instr_ready), int'(m_ready()));
        check("carry", int'(carry), m_carry);
        check("out_data", int'(out_data), (m_sel != 0) ? m_pc : m_r[3]);
    endtask

    task automatic wait_ready();
        for (int i = 0; i < RAM_DEPTH + 4 && !m_ready(); i++) step(1'b0, 1'b0, 6'b000000);
    endtask

    initial begin
        logic [5:0] ins;
        bit r, v;
        rst = 1'b1; instr_valid = 1'b0; instr = 6'b000000;
        @(negedge clk);
        step(1'b1, 1'b1, 6'b001111);
        step(1'b1, 1'b0, 6'b000000);
        check("reset out_data", int'(out_data), 3);
        check("reset carry", int'(carry), 0);
`ifndef HIDDENCPU_RAM_CLEAR_EN
        step(1'b0, 1'b0, 6'b000000);
        check("reset ready", int'(instr_ready), 1);
`endif
        wait_ready();

        step(1'b0, 1'b1, 6'b001111); check("add r3 first", int'(out_data), 6);
        step(1'b0, 1'b1, 6'b001111); check("add r3 second", int'(out_data), 12);
        step(1'b0, 1'b1, 6'b010001); check("sub borrow", int'(carry), 1);
        step(1'b0, 1'b1, 6'b100010);
        step(1'b0, 1'b1, 6'b100011); check("bcf taken pc", int'(out_data), 16);
        step(1'b0, 1'b1, 6'b100011); check("toggle back", int'(out_data), 12);
        step(1'b0, 1'b1, 6'b000101); check("add clears carry", int'(carry), 0);
        step(1'b0, 1'b1, 6'b100010);
        step(1'b0, 1'b1, 6'b100011); check("bcf not taken pc", int'(out_data), 20);
        step(1'b0, 1'b1, 6'b100011);
        step(1'b0, 1'b1, 6'b100001);
        step(1'b0, 1'b1, 6'b001111); check("add after store", int'(out_data), 24);
        step(1'b0, 1'b1, 6'b100000); check("load busy", int'(instr_ready), 0);
        step(1'b0, 1'b1, 6'b001111); check("load result", int'(out_data), 12);
        check("load ready again", int'(instr_ready), 1);
        step(1'b0, 1'b1, 6'b010000); check("sub self carry", int'(carry), 0);
        step(1'b0, 1'b0, 6'b001111); check("idle no change", int'(out_data), 12);

        // Reset landing on a pending LOAD abandons it.
        step(1'b0, 1'b1, 6'b100000);
        step(1'b1, 1'b0, 6'b000000); check("reset mid-load", int'(out_data), 3);
        wait_ready();

        for (int n = 0; n < 3000; n++) begin
            r   = ($urandom_range(0, 299) == 0);
            v   = ($urandom_range(0, 3) != 0);
            ins = 6'($urandom);
            if (ins[5:4] == 2'b10 && ins[1:0] == 2'b00 && !m_known[m_addr()]) ins[1:0] = 2'b01;
            step(r, v, ins);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
